alu_control_seq: RTL

- Sequential, parametrised successor to the combinational ALU control decoder of the RV32 core.
- Decodes ALUOp/func7/func3 into a 4-bit ALU opcode and registers the result behind a valid/ready handshake.
- Sequences multi-cycle ops (mul/div/rem) with a latency counter and a busy flag that the hazard unit uses to stall the pipeline.
- Flags illegal encodings.

---
 rtl/alu_control_seq.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_control_seq.sv
// alu_control_seq: sequential ALU control decoder for the RV32 core.
// Decodes ALUOp/func7/func3 into an ALU opcode, registers it behind a
// valid/ready handshake, and sequences multi-cycle M-extension ops.
//
// Build option: define RV_M_EXT_EN to enable MUL/MULH/DIV/REM decode and
// the BUSY latency path. Without it, func7=0000001 decodes as illegal and
// busy is tied low.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   ALUOp, func7, func3   decode inputs, sampled only at accept
//   flush                 synchronous kill of the in-flight op
//   out_valid / out_ready result handshake
//   alu_opcode            registered opcode (upper OPC_W-4 bits zero)
//   illegal               undecodable encoding, qualified by out_valid
//   busy                  a multi-cycle op is counting
module alu_control_seq #(
  parameter int unsigned OPC_W   = 4,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       func7,
  input  logic [2:0]       func3,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPC_W-1:0] alu_opcode,
  output logic             illegal,
  output logic             busy
);

  if (OPC_W < 4 || MUL_LAT < 2 || MUL_LAT > 15 || DIV_LAT < 2 || DIV_LAT > 15) begin : g_param_check
    $error("alu_control_seq: parameter out of range");
  end

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_ILL  = 4'b1111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef RV_M_EXT_EN
  localparam logic [6:0] F7_MD   = 7'b0000001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_REM  = 4'b1101;

  // Counter reload: one cycle is spent entering BUSY and one leaving it,
  // so out_valid appears exactly LAT cycles after the accept edge.
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 2);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1,
    S_BUSY = 2'd2
  } state_t;
`else
  typedef enum logic {
    S_IDLE = 1'b0,
    S_DONE = 1'b1
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [3:0] opc_q, opc_d;
  logic       ill_q, ill_d;
  logic [3:0] dec_op;
  logic       dec_ill;
  logic       accept;
`ifdef RV_M_EXT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       dec_mul;
  logic       dec_div;
`endif

  // Base R-type map (func7=0000000), shared by I-type non-shift ops.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    dec_op  = OP_ILL;
    dec_ill = 1'b1;
`ifdef RV_M_EXT_EN
    dec_mul = 1'b0;
    dec_div = 1'b0;
`endif
    case (ALUOp)
      2'b00: begin
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
      end
      2'b01: begin
        dec_op  = OP_SUB;
        dec_ill = 1'b0;
      end
      2'b10: begin
        case (func7)
          F7_BASE: begin
            dec_op  = base_op(func3);
            dec_ill = 1'b0;
          end
          F7_ALT: begin
            if (func3 == 3'b000) begin
              dec_op  = OP_SUB;
              dec_ill = 1'b0;
            end else if (func3 == 3'b101) begin
              dec_op  = OP_SRA;
              dec_ill = 1'b0;
            end
          end
`ifdef RV_M_EXT_EN
          F7_MD: begin
            case (func3)
              3'b000: begin dec_op = OP_MUL;  dec_ill = 1'b0; dec_mul = 1'b1; end
              3'b001: begin dec_op = OP_MULH; dec_ill = 1'b0; dec_mul = 1'b1; end
              3'b100: begin dec_op = OP_DIV;  dec_ill = 1'b0; dec_div = 1'b1; end
              3'b110: begin dec_op = OP_REM;  dec_ill = 1'b0; dec_div = 1'b1; end
              default: ;
            endcase
          end
`endif
          default: ;
        endcase
      end
      default: begin
        // I-type: func7 only qualifies the shift-immediate encodings.
        if (func3 == 3'b001) begin
          if (func7 == F7_BASE) begin
            dec_op  = OP_SLL;
            dec_ill = 1'b0;
          end
        end else if (func3 == 3'b101) begin
          if (func7 == F7_BASE) begin
            dec_op  = OP_SRL;
            dec_ill = 1'b0;
          end else if (func7 == F7_ALT) begin
            dec_op  = OP_SRA;
            dec_ill = 1'b0;
          end
        end else begin
          dec_op  = base_op(func3);
          dec_ill = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    ill_d   = ill_q;
`ifdef RV_M_EXT_EN
    cnt_d   = cnt_q;
`endif

    in_ready = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_DONE:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;

    case (state_q)
`ifdef RV_M_EXT_EN
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      S_DONE: begin
        if (out_ready && !accept) begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      opc_d   = dec_op;
      ill_d   = dec_ill;
      state_d = S_DONE;
`ifdef RV_M_EXT_EN
      if (dec_mul) begin
        state_d = S_BUSY;
        cnt_d   = MUL_CNT;
      end else if (dec_div) begin
        state_d = S_BUSY;
        cnt_d   = DIV_CNT;
      end
`endif
    end

    // flush wins over a simultaneous accept: the request is dropped and
    // the held result registers are left untouched.
    if (flush) begin
      state_d = S_IDLE;
      opc_d   = opc_q;
      ill_d   = ill_q;
`ifdef RV_M_EXT_EN
      cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      ill_q   <= 1'b0;
`ifdef RV_M_EXT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      ill_q   <= ill_d;
`ifdef RV_M_EXT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    alu_opcode      = '0;
    alu_opcode[3:0] = opc_q;
  end

  assign out_valid = (state_q == S_DONE);
  assign illegal   = ill_q;
`ifdef RV_M_EXT_EN
  assign busy      = (state_q == S_BUSY);
`else
  assign busy      = 1'b0;
`endif

endmodule
